// File: rtl/i2d_core_defines.sv
// rtl/i2d_core_defines.sv - shared core types, opcodes and fetch-stage definitions
package i2d_core_defines;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    // Major opcode occupying instr[31:26]; the NOP encoding doubles as the bubble opcode.
    localparam logic [5:0] OPCODE_NOP = 6'h13;

    // Low 26 bits of a bubble; distinguishes a fetch bubble from a real NOP.
    localparam logic [25:0] IF_BUBBLE = 26'(2);

    // S_IDLE: nothing outstanding; S_WAIT: outstanding, keep data;
    // S_DROP: outstanding, data belongs to a squashed path.
    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2,
        S_DROP  = 2'd3
    } if_state_t;

    typedef struct packed {
        addr_t  pc;
        instr_t instr;
    } if_entry_t;

    // Force an address onto a word boundary.
    function automatic addr_t word_align(input addr_t a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/core_if_fifo.sv
// rtl/core_if_fifo.sv - two-entry prefetch buffer holding {pc, instr} pairs
module core_if_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem [2];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop on an empty buffer or a push into a full one is ignored so the
    // pointers can never run past each other.
    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'(DEPTH)) || do_pop);

    // Pointer and occupancy tracking; clear empties the buffer in one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (clear) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= !wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= !rd_ptr;
            end
            if (do_push && !do_pop) begin
                count <= count + 2'd1;
            end else if (!do_push && do_pop) begin
                count <= count - 2'd1;
            end
        end
    end

    // Entry storage; contents are only observed when count is non-zero.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/core_if.sv
// rtl/core_if.sv - instruction fetch stage with two-entry prefetch and branch redirect
module core_if
    import i2d_core_defines::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_halt,
    input  logic        branch,
    input  logic [31:0] branch_target,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr
);

    if_state_t state;
    if_state_t state_nxt;
    addr_t     fetch_pc;
    addr_t     req_addr;
    logic [1:0] fifo_count;
    if_entry_t push_entry;
    if_entry_t head_entry;
    logic      has_room;
    logic      complete;
    logic      push;
    logic      pop;

    assign has_room = fifo_count < 2'(BUF_DEPTH);
    assign complete = imem_req && imem_ack;

    // Data from a squashed request, or completing on a redirect edge, is never kept.
    assign push = complete && (state != S_DROP) && !branch;
    assign pop  = (fifo_count != 2'd0) && !id_halt && !branch;

    assign push_entry = {fetch_pc, imem_rdata};

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_RESET;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a request issued or pending on a redirect edge becomes a drop.
    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET: state_nxt = S_IDLE;
            S_IDLE: begin
                if (has_room && !imem_ack) begin
                    state_nxt = branch ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_ack) begin
                    state_nxt = S_IDLE;
                end else if (branch) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_ack) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Memory request outputs; while outstanding the address comes from the
    // latched copy so a redirect cannot disturb it.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = req_addr;
        case (state)
            S_IDLE: begin
                imem_req  = has_room;
                imem_addr = fetch_pc;
            end
            S_WAIT, S_DROP: begin
                imem_req  = 1'b1;
                imem_addr = req_addr;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = req_addr;
            end
        endcase
    end

    // Fetch PC advance/redirect and capture of the address of a newly issued request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            if (branch) begin
                fetch_pc <= word_align(branch_target);
            end else if (push) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            if ((state == S_IDLE) && imem_req) begin
                req_addr <= fetch_pc;
            end
        end
    end

    core_if_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .clear (branch),
        .wdata (push_entry),
        .rdata (head_entry),
        .count (fifo_count)
    );

    // Present the buffer head, or a bubble tagged with the next fetch PC when empty.
    always_comb begin
        if (fifo_count != 2'd0) begin
            if_pc    = head_entry.pc;
            if_instr = head_entry.instr;
        end else begin
            if_pc    = fetch_pc;
            if_instr = {OPCODE_NOP, IF_BUBBLE};
        end
    end

endmodule

// File: tb/tb_core_if.sv
// tb/tb_core_if.sv - randomized and directed bench for core_if against a queue model
module tb_core_if;

    localparam logic [31:0] BUBBLE = 32'h4C00_0002;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_halt;
    logic        branch;
    logic [31:0] branch_target;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_pc;
    logic [31:0] w_instr;

    always #5 clk = ~clk;

    core_if u_dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .id_halt       (id_halt),
        .branch        (branch),
        .branch_target (branch_target),
        .if_pc         (if_pc),
        .if_instr      (if_instr)
    );

    core_if #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (w_req),
        .imem_addr     (w_addr),
        .imem_ack      (1'b1),
        .imem_rdata    (w_addr),
        .id_halt       (1'b0),
        .branch        (1'b0),
        .branch_target (32'h0),
        .if_pc         (w_pc),
        .if_instr      (w_instr)
    );

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [63:0] m_q[$];
    bit          m_started;
    bit          m_busy;
    bit          m_drop;
    logic [31:0] m_addr;
    int          lat_cnt;
    int          mode;
    int          lat;
    logic [31:0] held;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bound_chk(input string name, input bit ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: wait expired", name);
        end
    endtask

    task automatic model_reset();
        m_pc      = 32'h0;
        m_q.delete();
        m_started = 0;
        m_busy    = 0;
        m_drop    = 0;
        m_addr    = 32'h0;
        lat_cnt   = 0;
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_req"},    {31'b0, imem_req}, 32'h0);
        chk({tag, "_addr"},   imem_addr, 32'h0);
        chk({tag, "_pc"},     if_pc, 32'h0);
        chk({tag, "_instr"},  if_instr, BUBBLE);
        chk({tag, "_w_addr"}, w_addr, 32'hFFFF_FFF8);
        chk({tag, "_w_pc"},   w_pc, 32'hFFFF_FFF8);
    endtask

    // One clock: drive inputs at negedge, compare outputs against the model,
    // then advance the model by the rules for the edge just taken.
    task automatic step(input bit br, input logic [31:0] tgt, input bit halt);
        bit          e_req;
        logic [31:0] e_addr;
        bit          comp;
        e_req  = m_started && (m_busy || m_q.size() < 2);
        e_addr = m_busy ? m_addr : m_pc;
        branch        = br;
        branch_target = tgt;
        id_halt       = halt;
        case (mode)
            0: begin imem_ack = 1'b1; imem_rdata = e_addr; end
            1: begin imem_ack = e_req && (lat_cnt >= lat); imem_rdata = $urandom; end
            default: begin imem_ack = ($urandom_range(0, 1) == 1); imem_rdata = $urandom; end
        endcase
        #1;
        chk("imem_req", {31'b0, imem_req}, {31'b0, e_req});
        if (e_req) chk("imem_addr", imem_addr, e_addr);
        if (m_q.size() != 0) begin
            chk("if_pc", if_pc, m_q[0][63:32]);
            chk("if_instr", if_instr, m_q[0][31:0]);
        end else begin
            chk("if_pc_empty", if_pc, m_pc);
            chk("if_instr_bubble", if_instr, BUBBLE);
        end
        @(posedge clk);
        comp = e_req && imem_ack;
        if (br) begin
            m_q.delete();
            m_pc   = tgt & 32'hFFFF_FFFC;
            m_busy = e_req && !imem_ack;
            m_drop = m_busy;
            if (m_busy) m_addr = e_addr;
        end else begin
            if (m_q.size() != 0 && !halt) void'(m_q.pop_front());
            if (comp) begin
                if (!m_drop) begin
                    m_q.push_back({e_addr, imem_rdata});
                    m_pc = e_addr + 32'd4;
                end
                m_busy = 0;
                m_drop = 0;
            end else if (e_req) begin
                m_busy = 1;
                m_addr = e_addr;
            end
        end
        lat_cnt   = (e_req && !imem_ack) ? lat_cnt + 1 : 0;
        m_started = 1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        branch   = 1'b0;
        id_halt  = 1'b0;
        imem_ack = 1'b1;
        #1;
        reset_values("reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_busy(input string name);
        int n;
        n = 0;
        while (!m_busy && n < 10) begin
            step(0, 32'h0, 0);
            n++;
        end
        bound_chk(name, m_busy);
    endtask

    task automatic wait_head(input string name);
        int n;
        n = 0;
        while (m_q.size() == 0 && n < 12) begin
            step(0, 32'h0, 0);
            n++;
        end
        bound_chk(name, m_q.size() != 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; branch = 1'b0; branch_target = 32'h0; id_halt = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        mode = 0; lat = 0;
        model_reset();
        #2;
        @(negedge clk);

        // Zero-wait memory: one fetch per clock, and wrap from the top of memory.
        mode = 0;
        do_reset();
        step(0, 32'h0, 0);
        chk("t1_addr0", imem_addr, 32'h0);
        chk("t1_w_addr0", w_addr, 32'hFFFF_FFF8);
        step(0, 32'h0, 0);
        chk("t1_addr1", imem_addr, 32'h4);
        chk("t1_instr0", if_instr, 32'h0);
        chk("t1_w_addr1", w_addr, 32'hFFFF_FFFC);
        step(0, 32'h0, 0);
        chk("t1_addr2", imem_addr, 32'h8);
        chk("t1_instr1", if_instr, 32'h4);
        chk("t1_w_addr2", w_addr, 32'h0);
        step(0, 32'h0, 0);
        chk("t1_instr2", if_instr, 32'h8);
        repeat (10) step(0, 32'h0, 0);

        // Slow memory: acks three cycles late.
        mode = 1; lat = 3;
        repeat (40) step(0, 32'h0, 0);

        // Decode halt fills the buffer and stops requests.
        mode = 0;
        repeat (3) step(0, 32'h0, 0);
        held = m_q[0][31:0];
        repeat (4) step(0, 32'h0, 1);
        chk("t3_req_off", {31'b0, imem_req}, 32'h0);
        chk("t3_held", if_instr, held);
        repeat (8) step(0, 32'h0, 0);

        // Redirect while a request is outstanding.
        mode = 1; lat = 2;
        wait_busy("t4_busy");
        step(1, 32'h0000_0103, 0);
        begin
            int n;
            n = 0;
            while ((m_busy || m_drop) && n < 10) begin
                step(0, 32'h0, 0);
                n++;
            end
            bound_chk("t4_drop_done", !(m_busy || m_drop));
        end
        chk("t4_redirect_req", {31'b0, imem_req}, 32'h1);
        chk("t4_redirect_addr", imem_addr, 32'h0000_0100);
        wait_head("t4_head");
        chk("t4_target_pc", if_pc, 32'h0000_0100);

        // Second redirect while still dropping.
        mode = 1; lat = 3;
        wait_busy("t5_busy");
        step(1, 32'h0000_2000, 0);
        step(1, 32'h0000_3007, 0);
        wait_head("t5_head");
        chk("t5_target_pc", if_pc, 32'h0000_3004);

        // Random traffic.
        mode = 2;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) == 0);
        end

        // Reset in the middle of a pending request.
        mode = 1; lat = 3;
        wait_busy("t7_busy");
        #3;
        rst = 1'b0;
        #1;
        reset_values("t7_midreset");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        mode = 0;
        step(0, 32'h0, 0);
        chk("t7_restart_addr", imem_addr, 32'h0);
        step(0, 32'h0, 0);
        chk("t7_restart_instr", if_instr, 32'h0);
        repeat (5) step(0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_if.md
CORE_IF -- requirements
Module: core_if

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, meaning prefetch buffer entries (fixed at 2 for this revision).
REQ-003 SHALL have ports:
- clk  in  1  single core clock; all state on posedge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  32 (addr_t)  word-aligned fetch address
- imem_ack  in  1  request completed this cycle, data valid
- imem_rdata  in  32 (instr_t)  fetched instruction word
- id_halt  in  1  decode stalled; do not advance
- branch  in  1  redirect from decode
- branch_target  in  32 (addr_t)  redirect address
- if_pc  out  32 (addr_t)  PC of presented instruction
- if_instr  out  32 (instr_t)  instruction presented to decode

Function
REQ-004 SHALL hold fetch_pc, a 2-entry {pc,instr} FIFO and a 4-state FSM: S_RESET, S_IDLE (no outstanding request), S_WAIT (request outstanding, keep data), S_DROP (request outstanding, discard data).
REQ-005 SHALL move S_RESET -> S_IDLE on the first clock after rst deasserts, with imem_req=0 in S_RESET.
REQ-006 SHALL assert imem_req in S_IDLE only when FIFO count < 2, entering S_WAIT on that edge unless imem_ack is also high.
REQ-007 SHALL keep imem_req high and imem_addr stable from issue until the edge where imem_ack=1; at most one request outstanding.
REQ-008 SHALL treat imem_ack=1 while imem_req=1 as completion, accepting same-cycle acks (zero-wait memory sustains one fetch per clock).
REQ-009 SHALL, on completion in S_IDLE/S_WAIT without branch, push {fetch_pc, imem_rdata} and set fetch_pc <= fetch_pc + 4, wrapping 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-010 SHALL, on completion in S_DROP, discard imem_rdata, leave fetch_pc unchanged and go to S_IDLE.
REQ-011 SHALL drive if_pc/if_instr combinationally from the FIFO head when non-empty.
REQ-012 SHALL, when FIFO empty, drive if_instr = {OPCODE_NOP, 26'(2)} (bubble marker) and if_pc = fetch_pc.
REQ-013 SHALL pop the head on an edge where FIFO non-empty and id_halt=0; id_halt=1 holds head and outputs unchanged.
REQ-014 SHALL count: push+pop same edge -> unchanged; push only -> +1; pop only -> -1; push never occurs at count 2 (guaranteed by REQ-006).
REQ-015 SHALL, on an edge with branch=1, clear the FIFO, set fetch_pc <= {branch_target[31:2], 2'b00}, ignore any push/pop that edge.
REQ-016 SHALL, on branch with a request outstanding and imem_ack=0, go to S_DROP; with imem_ack=1 same edge, drop the data and go to S_IDLE.
REQ-017 SHALL give branch priority over id_halt and over completion.
REQ-018 SHALL, in S_DROP, not issue a new request until the dropped completion arrives; first redirected request issues the cycle after.
REQ-019 SHALL, on a second branch while in S_DROP, update fetch_pc and remain in S_DROP.
REQ-020 SHALL give two cycles from branch edge to the target instruction at if_instr with a zero-wait memory.

Reset
REQ-021 SHALL on rst=0 asynchronously set: state S_RESET, fetch_pc=RESET_PC, FIFO empty, imem_req=0, imem_addr=RESET_PC, if_pc=RESET_PC, if_instr={OPCODE_NOP,26'(2)}.
REQ-022 SHALL abandon any outstanding request on reset mid-transaction; imem_ack during reset is ignored.

Structure
REQ-023 SHALL take addr_t, instr_t, OPCODE_NOP from i2d_core_defines.sv; add there if_state_t enum and constant IF_BUBBLE = 26'(2).
REQ-024 SHALL implement the FIFO as sub-module core_if_fifo (push, pop, clear, data in/out, count, async active-low reset).

Verification
REQ-025 Reset release, imem_ack tied 1, rdata=addr -> imem_addr 0,4,8,... one per clock; if_instr sequence 0,4,8 starting cycle 2.
REQ-026 Ack 3 cycles late per request -> imem_addr stable during wait; each instruction presented once, bubbles between.
REQ-027 id_halt=1 for 4 cycles with ack tied 1 -> FIFO fills to 2, imem_req drops, if_instr held; resumes in order after release.
REQ-028 branch=1 target 32'h0000_0103 while request outstanding (ack 2 cycles later) -> stale data dropped, next imem_addr 32'h0000_0100, no stale instruction reaches if_instr.
REQ-029 RESET_PC=32'hFFFF_FFF8, ack tied 1 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-030 rst pulsed low while in S_WAIT -> outputs reach REQ-021 values immediately; fetch restarts at RESET_PC.
